// File: rtl/demux_rr_feeder.sv
// demux_rr_feeder: feeds a 1-to-8 demux from a serial valid/ready frame, round-robin over enabled channels.
// Optional FEEDER_PARITY_EN adds frame_parity (XOR of bits accepted in the current frame).
module demux_rr_feeder #(
    parameter int HOLD_CYC  = 1,
    parameter int FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] ch_mask,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       demux_in,
    output logic       demux_en,
    output logic [2:0] demux_sel,
    output logic       busy,
    output logic       frame_done,
    output logic       mask_err
`ifdef FEEDER_PARITY_EN
    ,
    output logic       frame_parity
`endif
);
    typedef enum logic [1:0] {IDLE, ACCEPT, DRIVE, DONE} state_t;
    state_t     state_q, state_d;
    logic [7:0] mask_q, mask_d, bit_cnt_q, bit_cnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] cur_ch_q, cur_ch_d, sel_q, sel_d, first_ch, next_ch;
    logic       ready_q, ready_d, in_q, in_d, en_q, en_d;
    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       start_ok, hs;

    assign start_ok = state_q == IDLE && start && ch_mask != '0;
    assign hs       = state_q == ACCEPT && din_valid && ready_q;

    // Descending scan so the lowest offset wins; offset 8 wraps to cur_ch itself.
    always_comb begin
        first_ch = '0;
        next_ch  = cur_ch_q;
        for (int i = 7; i >= 0; i--) begin
            if (ch_mask[i]) first_ch = 3'(i);
            if (mask_q[cur_ch_q + 3'(i + 1)]) next_ch = cur_ch_q + 3'(i + 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        cur_ch_d   = cur_ch_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = hold_cnt_q;
        ready_d    = ready_q;
        in_d       = in_q;
        en_d       = en_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    mask_d    = ch_mask;
                    cur_ch_d  = first_ch;
                    bit_cnt_d = '0;
                    ready_d   = 1'b1;
                    state_d   = ACCEPT;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ACCEPT: begin
                if (hs) begin
                    in_d       = din;
                    sel_d      = cur_ch_q;
                    en_d       = 1'b1;
                    hold_cnt_d = 4'(HOLD_CYC - 1);
                    ready_d    = 1'b0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                if (hold_cnt_q == '0) begin
                    en_d      = 1'b0;
                    in_d      = 1'b0;
                    cur_ch_d  = next_ch;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == 8'(FRAME_LEN - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        ready_d = 1'b1;
                        state_d = ACCEPT;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cur_ch_q   <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ready_q    <= 1'b0;
            in_q       <= 1'b0;
            en_q       <= 1'b0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            cur_ch_q   <= cur_ch_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ready_q    <= ready_d;
            in_q       <= in_d;
            en_q       <= en_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef FEEDER_PARITY_EN
    logic par_q, par_d;
    assign par_d = start_ok ? 1'b0 : hs ? par_q ^ din : par_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
    assign frame_parity = par_q;
`endif

    assign din_ready  = ready_q;
    assign demux_in   = in_q;
    assign demux_en   = en_q;
    assign demux_sel  = sel_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign mask_err   = err_q;
endmodule

// File: tb/tb_demux_rr_feeder.sv
// tb_demux_rr_feeder: directed bench; dut_a is HOLD_CYC=1/FRAME_LEN=8, dut_b is HOLD_CYC=3/FRAME_LEN=5.
module tb_demux_rr_feeder;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, din = 1'b0, din_valid = 1'b0;
    logic [7:0] ch_mask = '0;
    logic       rdy_a, in_a, en_a, busy_a, fd_a, err_a;
    logic       rdy_b, in_b, en_b, busy_b, fd_b, err_b;
    logic [2:0] sel_a, sel_b;
`ifdef FEEDER_PARITY_EN
    logic       par_a, par_b;
`endif
    int         errors = 0, checks = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux_rr_feeder #(.HOLD_CYC(1), .FRAME_LEN(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .din(din),
        .din_valid(din_valid), .din_ready(rdy_a), .demux_in(in_a), .demux_en(en_a),
        .demux_sel(sel_a), .busy(busy_a), .frame_done(fd_a), .mask_err(err_a)
`ifdef FEEDER_PARITY_EN
        , .frame_parity(par_a)
`endif
    );

    demux_rr_feeder #(.HOLD_CYC(3), .FRAME_LEN(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .din(din),
        .din_valid(din_valid), .din_ready(rdy_b), .demux_in(in_b), .demux_en(en_b),
        .demux_sel(sel_b), .busy(busy_b), .frame_done(fd_b), .mask_err(err_b)
`ifdef FEEDER_PARITY_EN
        , .frame_parity(par_b)
`endif
    );

    // Per-DUT monitors: log {sel,in} on each enable rise, flag wrong enable run lengths.
    logic [3:0] q_a[$], q_b[$];
    int run_a, run_b, len_bad_a, len_bad_b, rdy_bad_a, rdy_bad_b, fd_cnt_a, fd_cnt_b;
    logic prev_a, prev_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete(); run_a = 0; len_bad_a = 0; rdy_bad_a = 0; fd_cnt_a = 0; prev_a = 0;
        end else begin
            if (en_a) begin
                if (!prev_a) q_a.push_back({sel_a, in_a});
                run_a++;
                if (rdy_a) rdy_bad_a++;
            end else if (prev_a) begin
                if (run_a != 1) len_bad_a++;
                run_a = 0;
            end
            prev_a = en_a;
            if (fd_a) fd_cnt_a++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete(); run_b = 0; len_bad_b = 0; rdy_bad_b = 0; fd_cnt_b = 0; prev_b = 0;
        end else begin
            if (en_b) begin
                if (!prev_b) q_b.push_back({sel_b, in_b});
                run_b++;
                if (rdy_b) rdy_bad_b++;
            end else if (prev_b) begin
                if (run_b != 3) len_bad_b++;
                run_b = 0;
            end
            prev_b = en_b;
            if (fd_b) fd_cnt_b++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_frame(input logic [7:0] m);
        start   = 1'b1;
        ch_mask = m;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap, input logic use_b, output int t_hs);
        din_valid = 1'b0;
        repeat (gap) @(negedge clk);
        din       = b;
        din_valid = 1'b1;
        for (int t = 0; t < 40 && !(use_b ? rdy_b : rdy_a); t++) @(negedge clk);
        check("hs_ready", 32'(use_b ? rdy_b : rdy_a), 32'd1);
        t_hs = cyc;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input logic use_b);
        for (int t = 0; t < 40 && !(use_b ? fd_b : fd_a); t++) @(negedge clk);
        check("frame_done", 32'(use_b ? fd_b : fd_a), 32'd1);
    endtask

    logic [7:0] rot_bits = 8'h4D;
    logic [4:0] sp_bits  = 5'b11001;
    logic [2:0] sp_sel[5] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
    int ths[8];
    int th;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_a", 32'({rdy_a, in_a, en_a, sel_a, busy_a, fd_a, err_a}), 32'd0);
        check("rst_out_b", 32'({rdy_b, in_b, en_b, sel_b, busy_b, fd_b, err_b}), 32'd0);
        rst_n = 1'b1;
        start_frame(8'h00);
        check("mask_err", 32'(err_a), 32'd1);
        check("err_busy", 32'(busy_a), 32'd0);
        @(negedge clk);
        check("err_pulse", 32'(err_a), 32'd0);
        check("err_idle", 32'(busy_a), 32'd0);

        // Full rotation, continuous valid
        do_reset();
        start_frame(8'hFF);
        check("busy_a", 32'(busy_a), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(rot_bits[i], 0, 1'b0, ths[i]);
        for (int i = 1; i < 8; i++) check("hs_gap", 32'(ths[i] - ths[i-1]), 32'd2);
        wait_done(1'b0);
`ifdef FEEDER_PARITY_EN
        check("parity_a", 32'(par_a), 32'd0);
`endif
        @(negedge clk);
        check("done_idle_a", 32'({busy_a, fd_a}), 32'd0);
        check("fd_cnt_a", 32'(fd_cnt_a), 32'd1);
        check("log_len_a", 32'(q_a.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("rot_sel_in", 32'(q_a[i]), 32'({3'(i), rot_bits[i]}));
        check("en_len_a", 32'(len_bad_a), 32'd0);
        check("rdy_drive_a", 32'(rdy_bad_a), 32'd0);

        // Sparse mask with wrap, HOLD_CYC=3 and growing valid gaps
        do_reset();
        start_frame(8'b1000_0101);
        for (int i = 0; i < 5; i++) send_bit(sp_bits[i], i, 1'b1, th);
        wait_done(1'b1);
`ifdef FEEDER_PARITY_EN
        check("parity_b", 32'(par_b), 32'd1);
`endif
        @(negedge clk);
        check("done_idle_b", 32'({busy_b, fd_b}), 32'd0);
        check("fd_cnt_b", 32'(fd_cnt_b), 32'd1);
        check("log_len_b", 32'(q_b.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("sparse_sel_in", 32'(q_b[i]), 32'({sp_sel[i], sp_bits[i]}));
        check("en_len_b", 32'(len_bad_b), 32'd0);
        check("rdy_drive_b", 32'(rdy_bad_b), 32'd0);

        // Asynchronous reset while the 3rd bit is being driven
        do_reset();
        start_frame(8'h1E);
        send_bit(1'b1, 0, 1'b0, th);
        send_bit(1'b0, 0, 1'b0, th);
        send_bit(1'b1, 0, 1'b0, th);
        check("en_3rd", 32'({en_a, sel_a, in_a}), 32'({1'b1, 3'd3, 1'b1}));
        #2 rst_n = 1'b0;
        #1 check("abort_out", 32'({rdy_a, in_a, en_a, sel_a, busy_a, fd_a, err_a}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_fd", 32'({fd_cnt_a[0], busy_a}), 32'd0);
        start_frame(8'h1E);
        send_bit(1'b0, 0, 1'b0, th);
        @(negedge clk);
        check("restart_sel", 32'(q_a[0]), 32'({3'd1, 1'b0}));
        check("restart_busy", 32'(busy_a), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
